sobel_frame_seq: RTL and testbench

SOBEL_FRAME_SEQ -- requirements
Module: sobel_frame_seq

---
 rtl/sobel_frame_seq.sv | 186 ++++++++++++++++++
 tb/tb_sobel_frame_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_seq.sv
// sobel_frame_seq: frame sequencer around an external per-pixel colour filter.
// Source pixels are forwarded to the filter until N = IMG_W*IMG_H have been accepted.
// The three 8-bit colour results are joined into one 24-bit result word.
// Optional stall watchdog: define SOBEL_SEQ_WDOG_EN.
module sobel_frame_seq #(
    parameter int IMG_W   = 512,
    parameter int IMG_H   = 4,
    parameter int TMO_CYC = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        s_rgb_vld,
    output logic        s_rgb_busy,
    input  logic [23:0] s_rgb_data,
    output logic        f_rgb_vld,
    input  logic        f_rgb_busy,
    output logic [23:0] f_rgb_data,
    input  logic        f_r_vld,
    output logic        f_r_busy,
    input  logic [7:0]  f_r_data,
    input  logic        f_g_vld,
    output logic        f_g_busy,
    input  logic [7:0]  f_g_data,
    input  logic        f_b_vld,
    output logic        f_b_busy,
    input  logic [7:0]  f_b_data,
    output logic        m_res_vld,
    input  logic        m_res_busy,
    output logic [23:0] m_res_data,
    output logic        o_active,
    output logic        o_done,
    output logic        o_err
);
    localparam int N  = IMG_W * IMG_H;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] N_C = CW'(N);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    // channel index 2 = red, 1 = green, 0 = blue
    logic [2:0]      hold_full_q, hold_full_d;
    logic [2:0][7:0] hold_q, hold_d;
    logic            m_res_vld_q, m_res_vld_d;
    logic [23:0]     m_res_data_q, m_res_data_d;

    logic            in_open, in_xfer, out_xfer, fire, hold_lock;
    logic [2:0]      ch_vld, ch_busy, ch_cap, ch_avail;
    logic [2:0][7:0] ch_data, ch_val;

    // Source-to-filter pass-through, hold handshakes and result join
    always_comb begin
        in_open    = (state_q == RUN) && (in_cnt_q != N_C);
        f_rgb_vld  = in_open & s_rgb_vld;
        f_rgb_data = s_rgb_data;
        s_rgb_busy = in_open ? f_rgb_busy : 1'b1;
        in_xfer    = f_rgb_vld & ~f_rgb_busy;
        out_xfer   = m_res_vld_q & ~m_res_busy;
        hold_lock  = (state_q == IDLE) || (state_q == DONE);
        ch_vld     = {f_r_vld, f_g_vld, f_b_vld};
        ch_data    = {f_r_data, f_g_data, f_b_data};
        ch_busy    = hold_full_q | {3{hold_lock}};
        ch_cap     = ch_vld & ~ch_busy;
        // a channel counts as available while it is being captured, so the
        // last arriving colour joins the result on its own capture edge
        ch_avail   = hold_full_q | ch_cap;
        for (int i = 0; i < 3; i++)
            ch_val[i] = hold_full_q[i] ? hold_q[i] : ch_data[i];
        fire       = (&ch_avail) & (~m_res_vld_q | ~m_res_busy);
        {f_r_busy, f_g_busy, f_b_busy} = ch_busy;
    end

    assign m_res_vld  = m_res_vld_q;
    assign m_res_data = m_res_data_q;
    assign o_active   = (state_q == RUN) || (state_q == DRAIN);
    assign o_done     = (state_q == DONE);

`ifdef SOBEL_SEQ_WDOG_EN
    localparam int WW = $clog2(TMO_CYC + 1);
    logic [WW-1:0] wd_cnt_q, wd_cnt_d;
    logic          err_q, err_d, any_xfer;
    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    // Next-state: FSM, counters, holds, result register (and watchdog)
    always_comb begin
        state_d      = state_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        hold_full_d  = hold_full_q;
        hold_d       = hold_q;
        m_res_vld_d  = m_res_vld_q;
        m_res_data_d = m_res_data_q;

        if (in_xfer)
            in_cnt_d = in_cnt_q + CW'(1);
        if (out_xfer && o_active && (out_cnt_q != N_C))
            out_cnt_d = out_cnt_q + CW'(1);

        for (int i = 0; i < 3; i++) begin
            if (fire) begin
                hold_full_d[i] = 1'b0;
            end else if (ch_cap[i]) begin
                hold_full_d[i] = 1'b1;
                hold_d[i]      = ch_data[i];
            end
        end

        if (fire) begin
            m_res_vld_d  = 1'b1;
            m_res_data_d = {ch_val[2], ch_val[1], ch_val[0]};
        end else if (out_xfer) begin
            m_res_vld_d  = 1'b0;
        end

        case (state_q)
            IDLE: if (i_start) begin
                state_d   = RUN;
                in_cnt_d  = '0;
                out_cnt_d = '0;
            end
            RUN:   if (in_cnt_q == N_C)  state_d = DRAIN;
            DRAIN: if (out_cnt_q == N_C) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef SOBEL_SEQ_WDOG_EN
        wd_cnt_d = '0;
        err_d    = err_q;
        any_xfer = (s_rgb_vld & ~s_rgb_busy) | in_xfer | (|ch_cap) | out_xfer;
        if ((state_q == IDLE) && i_start)
            err_d = 1'b0;
        if (o_active && !any_xfer) begin
            if (wd_cnt_q == WW'(TMO_CYC - 1)) begin
                // abort the stalled frame and flush partial results
                state_d     = IDLE;
                err_d       = 1'b1;
                hold_full_d = '0;
                m_res_vld_d = 1'b0;
            end else begin
                wd_cnt_d = wd_cnt_q + WW'(1);
            end
        end
`endif
    end

    // State register with asynchronous reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            hold_full_q  <= '0;
            hold_q       <= '0;
            m_res_vld_q  <= 1'b0;
            m_res_data_q <= '0;
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            hold_full_q  <= hold_full_d;
            hold_q       <= hold_d;
            m_res_vld_q  <= m_res_vld_d;
            m_res_data_q <= m_res_data_d;
        end
    end

`ifdef SOBEL_SEQ_WDOG_EN
    // Watchdog counter and sticky error flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_sobel_frame_seq.sv
// Directed bench for sobel_frame_seq with IMG_W=4, IMG_H=2 (8-pixel frames).
// Optional watchdog section is built when SOBEL_SEQ_WDOG_EN is defined.
module tb_sobel_frame_seq;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic        s_rgb_vld = 1'b0, s_rgb_busy;
    logic [23:0] s_rgb_data = '0;
    logic        f_rgb_vld, f_rgb_busy;
    logic [23:0] f_rgb_data;
    logic        f_r_vld, f_r_busy, f_g_vld, f_g_busy, f_b_vld, f_b_busy;
    logic [7:0]  f_r_data, f_g_data, f_b_data;
    logic        m_res_vld, m_res_busy = 1'b0;
    logic [23:0] m_res_data;
    logic        o_active, o_done, o_err;

    // filter model: echo mode forwards colours combinationally, else manual
    logic        echo = 1'b1, man_rgb_busy = 1'b0;
    logic [2:0]  man_vld = '0;
    logic [23:0] man_data = '0;

    assign f_rgb_busy = echo ? (f_r_busy | f_g_busy | f_b_busy) : man_rgb_busy;
    assign f_r_vld  = echo ? f_rgb_vld : man_vld[2];
    assign f_g_vld  = echo ? f_rgb_vld : man_vld[1];
    assign f_b_vld  = echo ? f_rgb_vld : man_vld[0];
    assign f_r_data = echo ? f_rgb_data[23:16] : man_data[23:16];
    assign f_g_data = echo ? f_rgb_data[15:8]  : man_data[15:8];
    assign f_b_data = echo ? f_rgb_data[7:0]   : man_data[7:0];

    sobel_frame_seq #(.IMG_W(4), .IMG_H(2), .TMO_CYC(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .s_rgb_vld(s_rgb_vld), .s_rgb_busy(s_rgb_busy), .s_rgb_data(s_rgb_data),
        .f_rgb_vld(f_rgb_vld), .f_rgb_busy(f_rgb_busy), .f_rgb_data(f_rgb_data),
        .f_r_vld(f_r_vld), .f_r_busy(f_r_busy), .f_r_data(f_r_data),
        .f_g_vld(f_g_vld), .f_g_busy(f_g_busy), .f_g_data(f_g_data),
        .f_b_vld(f_b_vld), .f_b_busy(f_b_busy), .f_b_data(f_b_data),
        .m_res_vld(m_res_vld), .m_res_busy(m_res_busy), .m_res_data(m_res_data),
        .o_active(o_active), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int          total = 0, passed = 0, failed = 0;
    int          done_cnt = 0, fwd_cnt = 0, extra_fwd = 0;
    logic [23:0] rcv[$];
    logic [23:0] extra_pix = 24'hDEAD99;

    // monitors: results accepted by the sink, pixels accepted by the filter
    always @(posedge clk) begin
        if (m_res_vld && !m_res_busy) rcv.push_back(m_res_data);
        if (f_rgb_vld && !f_rgb_busy) begin
            fwd_cnt++;
            if (f_rgb_data == extra_pix) extra_fwd++;
        end
    end
    always @(negedge clk) if (o_done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pix(input logic [7:0] b, input int i);
        logic [7:0] k;
        k = 8'(i);
        return {b + k, b + 8'h40 + k, b + 8'h80 + k};
    endfunction

    // drive one source pixel, return at the negedge after it is accepted
    task automatic send(input logic [23:0] d);
        int n = 0;
        s_rgb_vld = 1'b1; s_rgb_data = d;
        #1;
        while (s_rgb_busy && n < 64) begin @(negedge clk); #1; n++; end
        chk("send_timeout", 32'(n < 64), 1);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_active && n < 100) begin @(negedge clk); n++; end
        chk("idle_timeout", 32'(n < 100), 1);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b);
        chk({tag, "_count"}, 32'(rcv.size()), 8);
        for (int i = 0; i < 8 && i < rcv.size(); i++)
            chk({tag, "_data"}, {8'h0, rcv[i]}, {8'h0, pix(b, i)});
        chk({tag, "_done"}, 32'(done_cnt), 1);
        chk({tag, "_active"}, {31'h0, o_active}, 0);
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_active", {31'h0, o_active}, 0);
        chk("rst_done", {31'h0, o_done}, 0);
        chk("rst_err", {31'h0, o_err}, 0);
        chk("rst_mvld", {31'h0, m_res_vld}, 0);
        chk("rst_mdata", {8'h0, m_res_data}, 0);
        chk("rst_sbusy", {31'h0, s_rgb_busy}, 1);
        chk("rst_rbusy", {31'h0, f_r_busy}, 1);
        @(negedge clk); rst = 1'b0; @(negedge clk);

        // full frame, no stalls
        done_cnt = 0; rcv.delete();
        pulse_start();
        chk("run_active", {31'h0, o_active}, 1);
        for (int i = 0; i < 8; i++) send(pix(8'h10, i));
        s_rgb_vld = 1'b0;
        wait_idle(); @(negedge clk);
        check_frame("f1", 8'h10);

        // 9th pixel must be refused
        done_cnt = 0; rcv.delete(); fwd_cnt = 0; extra_fwd = 0;
        pulse_start();
        for (int i = 0; i < 8; i++) send(pix(8'h20, i));
        s_rgb_vld = 1'b1; s_rgb_data = extra_pix; #1;
        chk("x9_sbusy", {31'h0, s_rgb_busy}, 1);
        chk("x9_fvld", {31'h0, f_rgb_vld}, 0);
        wait_idle(); repeat (3) @(negedge clk);
        s_rgb_vld = 1'b0;
        chk("x9_fwd_cnt", 32'(fwd_cnt), 8);
        chk("x9_never_fwd", 32'(extra_fwd), 0);
        check_frame("f2", 8'h20);

        // staggered colour arrival: r at t, g at t+3, b at t+5
        echo = 1'b0; man_rgb_busy = 1'b1;
        pulse_start();
        man_data = 24'hA1B2C3; man_vld = 3'b100; #1;
        chk("stag_rbusy_t", {31'h0, f_r_busy}, 0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            man_vld = {1'b0, c == 3, c == 5}; #1;
            if (c <= 5) begin
                chk("stag_rbusy", {31'h0, f_r_busy}, 1);
                chk("stag_mvld_lo", {31'h0, m_res_vld}, 0);
            end else begin
                chk("stag_mvld", {31'h0, m_res_vld}, 1);
                chk("stag_mdata", {8'h0, m_res_data}, 32'h00A1B2C3);
                chk("stag_rbusy_clr", {31'h0, f_r_busy}, 0);
            end
        end
        man_vld = '0;
        @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
        echo = 1'b1; man_rgb_busy = 1'b0;

        // sink back-pressure for 10 cycles once the holds fill
        done_cnt = 0; rcv.delete();
        m_res_busy = 1'b1;
        pulse_start();
        send(pix(8'h30, 0));
        send(pix(8'h30, 1));
        s_rgb_vld = 1'b1; s_rgb_data = pix(8'h30, 2);
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("bp_mdata", {8'h0, m_res_data}, {8'h0, pix(8'h30, 0)});
            chk("bp_gbusy", {31'h0, f_g_busy}, 1);
            @(negedge clk);
        end
        m_res_busy = 1'b0;
        for (int i = 2; i < 8; i++) send(pix(8'h30, i));
        s_rgb_vld = 1'b0;
        wait_idle(); @(negedge clk);
        check_frame("f3", 8'h30);

        // asynchronous reset mid-frame, then a complete frame
        pulse_start();
        for (int i = 0; i < 3; i++) send(pix(8'h50, i));
        s_rgb_vld = 1'b0;
        #2; rst = 1'b1; #1;
        chk("mrst_active", {31'h0, o_active}, 0);
        chk("mrst_mvld", {31'h0, m_res_vld}, 0);
        chk("mrst_mdata", {8'h0, m_res_data}, 0);
        chk("mrst_done", {31'h0, o_done}, 0);
        chk("mrst_err", {31'h0, o_err}, 0);
        chk("mrst_sbusy", {31'h0, s_rgb_busy}, 1);
        @(negedge clk); rst = 1'b0; @(negedge clk);
        done_cnt = 0; rcv.delete();
        pulse_start();
        for (int i = 0; i < 8; i++) send(pix(8'h60, i));
        s_rgb_vld = 1'b0;
        wait_idle(); @(negedge clk);
        check_frame("f4", 8'h60);

`ifdef SOBEL_SEQ_WDOG_EN
        // watchdog: filter input stalled permanently
        begin
            int n = 0;
            echo = 1'b0; man_rgb_busy = 1'b1;
            pulse_start();
            s_rgb_vld = 1'b1; s_rgb_data = pix(8'h70, 0);
            repeat (10) @(negedge clk);
            chk("wd_err_early", {31'h0, o_err}, 0);
            while (!o_err && n < 40) begin @(negedge clk); n++; end
            chk("wd_err", {31'h0, o_err}, 1);
            chk("wd_idle", {31'h0, o_active}, 0);
            s_rgb_vld = 1'b0; man_rgb_busy = 1'b0;
            pulse_start();
            chk("wd_err_clr", {31'h0, o_err}, 0);
            rst = 1'b1; @(negedge clk); rst = 1'b0; echo = 1'b1;
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
